axi_cmd_master: RTL and testbench



---
 rtl/axi_cmd_master_if.sv | 74 +++++++
 rtl/axi_cmd_master.sv | 217 +++++++++++++++++++++
 tb/tb_axi_cmd_master.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_cmd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_master_if
// Description : 32-bit AXI4 bus bundle between axi_cmd_master and the
//               MAC/PTP slave port. Channels: AW, W, B, AR, R.
//   modport master : drives address/data/valid fields, bready, rready
//   modport slave  : drives awready, wready, bresp/bvalid, arready, r*
// Revision    : 1.0  initial release
// ============================================================================
interface axi_cmd_master_if;
  // write address channel
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic        awlock;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  // write data channel
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  // write response channel
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  // read address channel
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic        arlock;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  // read data channel
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awlen, awlock, awsize, awburst, awcache, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arlen, arlock, arsize, arburst, arcache, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awlen, awlock, awsize, awburst, awcache, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arlen, arlock, arsize, arburst, arcache, arprot, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface
`default_nettype wire

// File: rtl/axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : axi_cmd_master
// Description : Converts a command + data-stream interface into single AXI4
//               INCR bursts (32-bit). One transaction outstanding at a time.
// Ports       : m_axi_aclk / m_axi_areset  clock, sync active-high reset
//               cmd_*      command handshake (write flag, address, beats-1)
//               usr_w*     write-data stream into the burst
//               usr_r*     read-data stream out of the burst
//               done*      end-of-command pulse, response, rlast error
//               m_axi      AXI4 master bundle (axi_cmd_master_if.master)
// Options     : AXI_CMD_MASTER_4K_CHECK_EN - reject bursts crossing 4 KB;
//               rejected writes drain the stream and finish with SLVERR.
// Revision    : 1.0  initial release
// ============================================================================
module axi_cmd_master #(
  parameter logic [3:0] P_CACHE = 4'b0011,
  parameter logic [2:0] P_PROT  = 3'b000
) (
  input  wire               m_axi_aclk,
  input  wire               m_axi_areset,
  input  wire               cmd_valid,
  output logic              cmd_ready,
  input  wire               cmd_write,
  input  wire  [31:0]       cmd_addr,
  input  wire  [7:0]        cmd_len,
  input  wire  [31:0]       usr_wdata,
  input  wire  [3:0]        usr_wstrb,
  input  wire               usr_wvalid,
  output logic              usr_wready,
  output logic [31:0]       usr_rdata,
  output logic              usr_rvalid,
  input  wire               usr_rready,
  output logic              usr_rlast,
  output logic              done,
  output logic [1:0]        done_resp,
  output logic              done_err_last,
  axi_cmd_master_if.master  m_axi
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_AW   = 3'd1;
  localparam logic [2:0] S_W    = 3'd2;
  localparam logic [2:0] S_B    = 3'd3;
  localparam logic [2:0] S_AR   = 3'd4;
  localparam logic [2:0] S_R    = 3'd5;
  localparam logic [2:0] S_DONE = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  beat_cnt_q, beat_cnt_d;
  logic [1:0]  resp_acc_q, resp_acc_d;
  logic        err_last_q, err_last_d;
  logic        reject_q, reject_d;
  logic [1:0]  done_resp_q, done_resp_d;
  logic        done_err_last_q, done_err_last_d;

  logic run;
  logic last_beat;
  logic w_beat;
  logic r_beat;
  logic crosses_4k;

  // Every handshake output is forced low while reset is held, so the bus is
  // quiet even before the first reset edge settles the state register.
  assign run       = ~m_axi_areset;
  assign last_beat = (beat_cnt_q == len_q);

`ifdef AXI_CMD_MASTER_4K_CHECK_EN
  // Byte offset one past the final beat, relative to the 4 KB page.
  logic [13:0] span_end;
  assign span_end   = {2'b00, cmd_addr[11:0]} + {4'b0000, cmd_len, 2'b00} + 14'd4;
  assign crosses_4k = (span_end > 14'd4096);
`else
  assign crosses_4k = 1'b0;
`endif

  // ---------------- outputs ----------------
  assign cmd_ready = run && (state_q == S_IDLE);
  assign done      = run && (state_q == S_DONE);
  assign done_resp     = done_resp_q;
  assign done_err_last = done_err_last_q;

  assign m_axi.awaddr  = addr_q & ~32'h3;
  assign m_axi.awlen   = len_q;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awsize  = 3'b010;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awcache = P_CACHE;
  assign m_axi.awprot  = P_PROT;
  assign m_axi.awvalid = run && (state_q == S_AW);

  assign m_axi.araddr  = addr_q & ~32'h3;
  assign m_axi.arlen   = len_q;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arsize  = 3'b010;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arcache = P_CACHE;
  assign m_axi.arprot  = P_PROT;
  assign m_axi.arvalid = run && (state_q == S_AR);

  // A rejected write never reaches the bus; its stream is swallowed here.
  assign m_axi.wdata  = usr_wdata;
  assign m_axi.wstrb  = usr_wstrb;
  assign m_axi.wlast  = last_beat;
  assign m_axi.wvalid = run && (state_q == S_W) && !reject_q && usr_wvalid;
  assign usr_wready   = run && (state_q == S_W) && (reject_q || m_axi.wready);

  assign m_axi.bready = run && (state_q == S_B);

  assign usr_rdata    = m_axi.rdata;
  assign usr_rlast    = last_beat;
  assign usr_rvalid   = run && (state_q == S_R) && m_axi.rvalid;
  assign m_axi.rready = run && (state_q == S_R) && usr_rready;

  assign w_beat = usr_wvalid && usr_wready;
  assign r_beat = m_axi.rvalid && m_axi.rready;

  // ---------------- next state ----------------
  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    beat_cnt_d      = beat_cnt_q;
    resp_acc_d      = resp_acc_q;
    err_last_d      = err_last_q;
    reject_d        = reject_q;
    done_resp_d     = done_resp_q;
    done_err_last_d = done_err_last_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d     = cmd_addr;
          len_d      = cmd_len;
          beat_cnt_d = 8'd0;
          resp_acc_d = 2'b00;
          err_last_d = 1'b0;
          reject_d   = crosses_4k;
          if (crosses_4k) begin
            resp_acc_d = 2'b10;
            state_d    = cmd_write ? S_W : S_DONE;
          end else begin
            state_d    = cmd_write ? S_AW : S_AR;
          end
        end
      end
      S_AW: begin
        if (m_axi.awready) state_d = S_W;
      end
      S_W: begin
        if (w_beat) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
          if (last_beat) state_d = reject_q ? S_DONE : S_B;
        end
      end
      S_B: begin
        if (m_axi.bvalid) begin
          resp_acc_d = m_axi.bresp;
          state_d    = S_DONE;
        end
      end
      S_AR: begin
        if (m_axi.arready) state_d = S_R;
      end
      S_R: begin
        if (r_beat) begin
          // Response codes are ordered OKAY < EXOKAY < SLVERR < DECERR.
          if (m_axi.rresp > resp_acc_q) resp_acc_d = m_axi.rresp;
          if (m_axi.rlast != last_beat) err_last_d = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Leave on our own count; a missing or late rlast is not awaited.
          if (last_beat) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Result registers load on entry to DONE and then hold until the next one.
    if ((state_d == S_DONE) && (state_q != S_DONE)) begin
      done_resp_d     = resp_acc_d;
      done_err_last_d = err_last_d;
    end
  end

  always_ff @(posedge m_axi_aclk) begin
    if (m_axi_areset) begin
      state_q         <= S_IDLE;
      addr_q          <= 32'd0;
      len_q           <= 8'd0;
      beat_cnt_q      <= 8'd0;
      resp_acc_q      <= 2'b00;
      err_last_q      <= 1'b0;
      reject_q        <= 1'b0;
      done_resp_q     <= 2'b00;
      done_err_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      beat_cnt_q      <= beat_cnt_d;
      resp_acc_q      <= resp_acc_d;
      err_last_q      <= err_last_d;
      reject_q        <= reject_d;
      done_resp_q     <= done_resp_d;
      done_err_last_q <= done_err_last_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_cmd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_cmd_master
// Description : Self-checking bench for axi_cmd_master. A randomised AXI
//               slave and user-stream agents surround the DUT; expectations
//               come from a command-level model (memory function, response
//               max, beat counts). Honours AXI_CMD_MASTER_4K_CHECK_EN.
// Revision    : 1.0  initial release
// ============================================================================
module tb_axi_cmd_master;

  logic        clk;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [31:0] usr_wdata;
  logic [3:0]  usr_wstrb;
  logic        usr_wvalid, usr_wready;
  logic [31:0] usr_rdata;
  logic        usr_rvalid, usr_rready, usr_rlast;
  logic        done;
  logic [1:0]  done_resp;
  logic        done_err_last;

  axi_cmd_master_if bus ();

  axi_cmd_master dut (
    .m_axi_aclk    (clk),
    .m_axi_areset  (rst),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_len       (cmd_len),
    .usr_wdata     (usr_wdata),
    .usr_wstrb     (usr_wstrb),
    .usr_wvalid    (usr_wvalid),
    .usr_wready    (usr_wready),
    .usr_rdata     (usr_rdata),
    .usr_rvalid    (usr_rvalid),
    .usr_rready    (usr_rready),
    .usr_rlast     (usr_rlast),
    .done          (done),
    .done_resp     (done_resp),
    .done_err_last (done_err_last),
    .m_axi         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave memory contents: a fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- environment configuration / observations ----------------
  bit          fast;
  logic [1:0]  rresp_cfg [256];
  int          rlast_beat;
  logic [1:0]  bresp_cfg;

  int          aw_cnt, ar_cnt, fields_bad;
  logic [31:0] aw_addr_seen, ar_addr_seen;
  logic [7:0]  aw_len_seen, ar_len_seen;
  logic [31:0] bw_data_q [$];
  bit          bw_last_q [$];
  logic [31:0] uw_q [$];
  int          uw_acc;
  logic [31:0] ur_data_q [$];
  bit          ur_last_q [$];

  bit b_pend, b_on, r_on, uw_on;
  int r_left, r_beat;

  // AXI slave + user stream agents: sample at posedge, drive at negedge.
  initial begin : env
    bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    bus.rvalid = 1'b0; bus.rdata = 32'd0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    usr_wvalid = 1'b0; usr_wdata = 32'd0; usr_wstrb = 4'hF; usr_rready = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        b_pend = 0; b_on = 0; r_on = 0; r_left = 0; uw_on = 0;
        uw_q.delete();
      end else begin
        if (bus.awvalid && bus.awready) begin
          aw_cnt++; aw_addr_seen = bus.awaddr; aw_len_seen = bus.awlen;
          if (bus.awsize !== 3'b010 || bus.awburst !== 2'b01 || bus.awlock !== 1'b0 ||
              bus.awcache !== 4'b0011 || bus.awprot !== 3'b000) fields_bad++;
        end
        if (bus.arvalid && bus.arready) begin
          ar_cnt++; ar_addr_seen = bus.araddr; ar_len_seen = bus.arlen;
          r_left = int'(bus.arlen) + 1; r_beat = 0;
          if (bus.arsize !== 3'b010 || bus.arburst !== 2'b01 || bus.arlock !== 1'b0 ||
              bus.arcache !== 4'b0011 || bus.arprot !== 3'b000) fields_bad++;
        end
        if (bus.wvalid && bus.wready) begin
          bw_data_q.push_back(bus.wdata); bw_last_q.push_back(bus.wlast);
          if (bus.wlast) b_pend = 1;
        end
        if (bus.bvalid && bus.bready) b_on = 0;
        if (bus.rvalid && bus.rready) begin r_on = 0; r_beat++; r_left--; end
        if (usr_wvalid && usr_wready) begin
          void'(uw_q.pop_front()); uw_on = 0; uw_acc++;
        end
        if (usr_rvalid && usr_rready) begin
          ur_data_q.push_back(usr_rdata); ur_last_q.push_back(usr_rlast);
        end
      end
      @(negedge clk);
      if (rst) begin
        bus.awready = 1'b0; bus.wready = 1'b0; bus.arready = 1'b0;
        bus.bvalid = 1'b0; bus.rvalid = 1'b0; usr_wvalid = 1'b0; usr_rready = 1'b0;
      end else begin
        bus.awready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        bus.wready  = fast ? 1'b1 : 1'($urandom_range(0, 1));
        bus.arready = fast ? 1'b1 : 1'($urandom_range(0, 1));
        if (!b_on && b_pend && (fast || $urandom_range(0, 1) == 1)) begin
          b_on = 1; b_pend = 0;
        end
        bus.bvalid = b_on;
        bus.bresp  = bresp_cfg;
        if (!r_on && r_left > 0 && (fast || $urandom_range(0, 2) != 0)) r_on = 1;
        bus.rvalid = r_on;
        bus.rdata  = mem_word(ar_addr_seen + 32'(4 * r_beat));
        bus.rresp  = rresp_cfg[r_beat[7:0]];
        bus.rlast  = (r_beat == rlast_beat);
        if (!uw_on && uw_q.size() > 0 && (fast || $urandom_range(0, 1) == 1)) uw_on = 1;
        usr_wvalid = uw_on;
        usr_wdata  = (uw_q.size() > 0) ? uw_q[0] : 32'd0;
        usr_wstrb  = 4'hF;
        usr_rready = fast ? 1'b1 : 1'($urandom_range(0, 1));
      end
    end
  end

  // Issue one command from a negedge; returns at the negedge where done is
  // seen (or the bound expires). cyc counts the accept cycle as cycle 1.
  task automatic run_cmd(input bit wr, input logic [31:0] addr, input logic [7:0] len,
                         output int cyc, output bit got);
    int n;
    bw_data_q.delete(); bw_last_q.delete(); ur_data_q.delete(); ur_last_q.delete();
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 2;
    while (!done && cyc < 5000) begin @(negedge clk); cyc++; end
    got = done;
  endtask

  // Reference for a read: responses maxed, data from the memory function.
  function automatic logic [1:0] max_rresp(input int len);
    logic [1:0] m;
    m = 2'b00;
    for (int i = 0; i <= len; i++) if (rresp_cfg[i] > m) m = rresp_cfg[i];
    return m;
  endfunction

  task automatic check_read(input string tag, input logic [31:0] addr, input int len);
    int bad;
    bad = 0;
    check({tag, "_nbeats"}, ur_data_q.size(), len + 1);
    if (ur_data_q.size() == len + 1)
      for (int i = 0; i <= len; i++) begin
        if (ur_data_q[i] !== mem_word((addr & ~32'h3) + 32'(4 * i))) bad++;
        if (ur_last_q[i] !== (i == len)) bad++;
      end
    check({tag, "_data_rlast"}, bad, 0);
  endtask

  task automatic check_write(input string tag, input logic [31:0] exp_words [$]);
    int bad;
    bad = 0;
    check({tag, "_nbeats"}, bw_data_q.size(), exp_words.size());
    if (bw_data_q.size() == exp_words.size())
      for (int i = 0; i < exp_words.size(); i++) begin
        if (bw_data_q[i] !== exp_words[i]) bad++;
        if (bw_last_q[i] !== (i == exp_words.size() - 1)) bad++;
      end
    check({tag, "_data_wlast"}, bad, 0);
  endtask

  initial begin : main
    int          cyc;
    bit          got;
    logic [31:0] a;
    int          l;
    int          acc0, aw0, n;
    logic [1:0]  exp_resp;
    logic [31:0] words [$];

    checks = 0; errors = 0;
    fast = 1; rlast_beat = 0; bresp_cfg = 2'b00;
    for (int i = 0; i < 256; i++) rresp_cfg[i] = 2'b00;
    aw_cnt = 0; ar_cnt = 0; fields_bad = 0; uw_acc = 0;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_len = 8'd0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_bready", bus.bready, 0);
    check("rst_done", done, 0);
    check("rst_awaddr", bus.awaddr, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_done_resp", done_resp, 0);
    check("post_rst_done_err", done_err_last, 0);

    // ---- single write, zero wait states ----
    words = '{32'hDEAD_BEEF};
    uw_q.push_back(32'hDEAD_BEEF);
    run_cmd(1, 32'h4000_0010, 8'd0, cyc, got);
    check("w1_done_seen", got, 1);
    check("w1_done_cycle", cyc, 5);
    check("w1_done_resp", done_resp, 2'b00);
    check("w1_awaddr", aw_addr_seen, 32'h4000_0010);
    check("w1_awlen", aw_len_seen, 8'd0);
    check_write("w1", words);
    @(negedge clk);
    check("w1_done_pulse", done, 0);
    check("w1_cmd_ready_back", cmd_ready, 1);

    // ---- read burst len 7 with random stalls on both sides ----
    fast = 0; rlast_beat = 7;
    a = ($urandom & 32'hFFFF_F000) | 32'h100;
    run_cmd(0, a, 8'd7, cyc, got);
    check("r8_done_seen", got, 1);
    check("r8_araddr", ar_addr_seen, a);
    check_read("r8", a, 7);
    check("r8_done_resp", done_resp, 2'b00);
    check("r8_err_last", done_err_last, 0);
    @(negedge clk);

    // ---- read 4 beats: SLVERR on beat 2, DECERR on beat 3 ----
    rresp_cfg[1] = 2'b10; rresp_cfg[2] = 2'b11; rlast_beat = 3;
    a = 32'h1000_0040;
    run_cmd(0, a, 8'd3, cyc, got);
    check("r4err_done_seen", got, 1);
    check("r4err_done_resp", done_resp, 2'b11);
    check_read("r4err", a, 3);
    rresp_cfg[1] = 2'b00; rresp_cfg[2] = 2'b00;
    @(negedge clk);
    check("r4err_resp_hold", done_resp, 2'b11);

    // ---- read len 3 with early rlast on beat 2 ----
    rlast_beat = 1;
    a = 32'h2000_0080;
    run_cmd(0, a, 8'd3, cyc, got);
    check("early_done_seen", got, 1);
    check("early_err_last", done_err_last, 1);
    check("early_done_resp", done_resp, 2'b00);
    check_read("early", a, 3);
    @(negedge clk);

    // ---- random commands against the model ----
    for (int t = 0; t < 8; t++) begin
      l = $urandom_range(0, 15);
      a = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 1) == 1) begin
        bresp_cfg = 2'($urandom_range(0, 3));
        words.delete();
        for (int i = 0; i <= l; i++) begin
          words.push_back($urandom);
          uw_q.push_back(words[i]);
        end
        run_cmd(1, a, 8'(l), cyc, got);
        check("rnd_w_done_seen", got, 1);
        check("rnd_w_awaddr", aw_addr_seen, a);
        check("rnd_w_awlen", aw_len_seen, 32'(l));
        check("rnd_w_done_resp", done_resp, bresp_cfg);
        check_write("rnd_w", words);
      end else begin
        rlast_beat = l;
        for (int i = 0; i <= l; i++) rresp_cfg[i] = 2'($urandom_range(0, 3));
        exp_resp = max_rresp(l);
        run_cmd(0, a, 8'(l), cyc, got);
        check("rnd_r_done_seen", got, 1);
        check("rnd_r_arlen", ar_len_seen, 32'(l));
        check("rnd_r_done_resp", done_resp, exp_resp);
        check("rnd_r_err_last", done_err_last, 0);
        check_read("rnd_r", a, l);
        for (int i = 0; i < 256; i++) rresp_cfg[i] = 2'b00;
      end
      @(negedge clk);
    end
    bresp_cfg = 2'b00;

    // ---- reset in the middle of a 16-beat write ----
    fast = 0;
    for (int i = 0; i < 16; i++) uw_q.push_back(32'hC0DE_0000 + 32'(i));
    acc0 = uw_acc;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000_0000; cmd_len = 8'd15;
    n = 0;
    while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (uw_acc - acc0 < 3 && n < 2000) begin @(negedge clk); n++; end
    check("mid_rst_reached_beat3", uw_acc - acc0, 3);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_awvalid", bus.awvalid, 0);
    check("mid_rst_wvalid", bus.wvalid, 0);
    check("mid_rst_arvalid", bus.arvalid, 0);
    check("mid_rst_bready", bus.bready, 0);
    check("mid_rst_usr_rvalid", usr_rvalid, 0);
    check("mid_rst_done", done, 0);
    rst = 1'b0;
    @(negedge clk);
    fast = 1;
    words = '{32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
    foreach (words[i]) uw_q.push_back(words[i]);
    run_cmd(1, 32'h3000_0100, 8'd2, cyc, got);
    check("after_rst_done_seen", got, 1);
    check("after_rst_awlen", aw_len_seen, 8'd2);
    check("after_rst_done_resp", done_resp, 2'b00);
    check_write("after_rst", words);
    @(negedge clk);

    // ---- write crossing a 4 KB page ----
    words = '{32'hAAAA_0001, 32'hAAAA_0002};
    foreach (words[i]) uw_q.push_back(words[i]);
    aw0 = aw_cnt;
    acc0 = uw_acc;
    run_cmd(1, 32'h0000_0FFC, 8'd1, cyc, got);
    check("x4k_done_seen", got, 1);
`ifdef AXI_CMD_MASTER_4K_CHECK_EN
    check("x4k_no_aw", aw_cnt - aw0, 0);
    check("x4k_drained", uw_acc - acc0, 2);
    check("x4k_no_wbeats", bw_data_q.size(), 0);
    check("x4k_done_resp", done_resp, 2'b10);
`else
    check("x4k_aw_issued", aw_cnt - aw0, 1);
    check("x4k_awaddr", aw_addr_seen, 32'h0000_0FFC);
    check("x4k_done_resp", done_resp, 2'b00);
    check_write("x4k", words);
`endif
    @(negedge clk);

    check("addr_fields", fields_bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
